// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO, baud divider and framing FSM.
// Define UART_TX_BREAK_EN to add the break_req port and Break state.
module uart_tx_buffered #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          tx_en,
    input  logic [1:0]                    parity_type,
    input  logic                          nstop,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          data_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    output logic                          tx_rdy,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BI = $clog2(DATA_WIDTH);
`ifdef UART_TX_BREAK_EN
    localparam int BW = $clog2(DATA_WIDTH + 3);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;

    state_t                state;
    logic [DIV_WIDTH-1:0]  cnt;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DATA_WIDTH-1:0] shift;
    logic [BI-1:0]         bit_idx;
    logic                  par_en;
    logic                  par_bit;
    logic                  nstop_q;
    logic                  tick;
    logic                  frame_end;
    logic                  decide;
    logic                  brk_go;
`ifdef UART_TX_BREAK_EN
    logic [BW-1:0]         brk_n;
`endif

    assign tx_rdy = tx_en && (fifo_count != CW'(FIFO_DEPTH));
    assign push   = data_valid && tx_rdy;
    assign head   = mem[rd_ptr];
    assign busy   = (state != S_IDLE) || (fifo_count != '0);

    assign tick      = (cnt == '0);
    assign frame_end = tick && ((state == S_STOP1 && !nstop_q) ||
                                state == S_STOP2);
    // Idle and the end of a frame share one start/break decision point.
    assign decide    = (state == S_IDLE) || frame_end;
`ifdef UART_TX_BREAK_EN
    assign brk_go    = break_req;
`else
    assign brk_go    = 1'b0;
`endif
    assign pop = decide && !brk_go && tx_en && (fifo_count != '0);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            cnt     <= '0;
            div_q   <= '0;
            shift   <= '0;
            bit_idx <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            nstop_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_n   <= '0;
`endif
        end else if (decide && brk_go) begin
`ifdef UART_TX_BREAK_EN
            state   <= S_BREAK;
            txd     <= 1'b0;
            cnt     <= baud_div;
            div_q   <= baud_div;
            nstop_q <= 1'b0;
            brk_n   <= '0;
`endif
        end else if (pop) begin
            state   <= S_START;
            txd     <= 1'b0;
            cnt     <= baud_div;
            div_q   <= baud_div;
            nstop_q <= nstop;
            par_en  <= parity_type[1];
            par_bit <= (^head) ^ parity_type[0];
            shift   <= head;
        end else if (decide) begin
            state <= S_IDLE;
            txd   <= 1'b1;
        end else if (!tick) begin
            cnt <= cnt - DIV_WIDTH'(1);
        end else begin
            cnt <= div_q;
            unique case (state)
                S_START: begin
                    state   <= S_DATA;
                    txd     <= shift[0];
                    bit_idx <= '0;
                end
                S_DATA: begin
                    if (bit_idx == BI'(DATA_WIDTH - 1)) begin
                        state <= par_en ? S_PARITY : S_STOP1;
                        txd   <= par_en ? par_bit : 1'b1;
                    end else begin
                        shift   <= shift >> 1;
                        txd     <= shift[1];
                        bit_idx <= bit_idx + BI'(1);
                    end
                end
                S_PARITY: begin
                    state <= S_STOP1;
                    txd   <= 1'b1;
                end
                S_STOP1: begin
                    state <= S_STOP2;
                    txd   <= 1'b1;
                end
`ifdef UART_TX_BREAK_EN
                // Hold the line low for at least DATA_WIDTH+2 periods.
                S_BREAK: begin
                    if (!break_req && brk_n >= BW'(DATA_WIDTH + 1)) begin
                        state <= S_STOP1;
                        txd   <= 1'b1;
                    end else if (brk_n < BW'(DATA_WIDTH + 1)) begin
                        brk_n <= brk_n + BW'(1);
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: directed frames plus random traffic
// compared cycle by cycle against a waveform-queue reference model.
module tb_uart_tx_buffered;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int VW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          tx_en;
    logic [1:0]    parity_type;
    logic          nstop;
    logic [VW-1:0] baud_div;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          tx_rdy;
    logic          txd;
    logic          busy;
    logic [2:0]    fifo_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] q[$];
    logic          wave[$];

    uart_tx_buffered #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(FD),
        .DIV_WIDTH (VW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_en      (tx_en),
        .parity_type(parity_type),
        .nstop      (nstop),
        .baud_div   (baud_div),
        .data_in    (data_in),
        .data_valid (data_valid),
        .tx_rdy     (tx_rdy),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      tag, got, exp, $time);
    endtask

    // Expected line samples of one whole frame, one entry per clock.
    task automatic build_frame(input logic [DW-1:0] d, input logic [1:0] pt,
                               input logic ns, input logic [VW-1:0] div);
        logic bits[$];
        int   reps;
        reps = int'(div) + 1;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pt >= 2) bits.push_back((($countones(d) % 2) == 1) ^ (pt == 3));
        bits.push_back(1'b1);
        if (ns) bits.push_back(1'b1);
        foreach (bits[i])
            for (int r = 0; r < reps; r++) wave.push_back(bits[i]);
    endtask

    task automatic model_step();
        logic do_push;
        logic [DW-1:0] d;
        do_push = data_valid && tx_en && (q.size() < FD);
        if (wave.size() > 0) void'(wave.pop_front());
        if (wave.size() == 0 && tx_en && q.size() > 0) begin
            d = q.pop_front();
            build_frame(d, parity_type, nstop, baud_div);
        end
        if (do_push) q.push_back(data_in);
    endtask

    function automatic logic exp_txd();
        return (wave.size() > 0) ? wave[0] : 1'b1;
    endfunction

    task automatic check_outputs();
        check("txd", 32'(txd), 32'(exp_txd()));
        check("busy", 32'(busy), 32'((wave.size() > 0) || (q.size() > 0)));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1;
        check("tx_rdy", 32'(tx_rdy), 32'(tx_en && (q.size() < FD)));
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        q.delete();
        wave.delete();
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        data_valid = 1'b0;
        while (busy && n < limit) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [9:0] seq;
        int         n;
        int         acc;
        logic       rdy6;
        logic       par_s;

        reset       = 1'b0;
        tx_en       = 1'b1;
        parity_type = 2'd0;
        nstop       = 1'b0;
        baud_div    = '0;
        data_in     = '0;
        data_valid  = 1'b0;
        @(negedge clock);
        do_reset();
        check("rst_rdy", 32'(tx_rdy), 32'd1);

        // 0xA5, no parity, one stop, divider 0
        data_in    = 8'hA5;
        data_valid = 1'b1;
        cycle();
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            seq[i] = txd;
        end
        check("seq_a5", 32'(seq), 32'h34A);
        cycle();
        check("busy_fall_a5", 32'(busy), 32'd0);

        // 0x07, even parity, divider 3: 11 bits of 4 cycles
        baud_div    = 16'd3;
        parity_type = 2'd2;
        data_in     = 8'h07;
        data_valid  = 1'b1;
        cycle();
        data_valid = 1'b0;
        n = 0;
        par_s = 1'b0;
        for (int i = 0; i < 100 && (i == 0 || busy); i++) begin
            cycle();
            if (busy) n++;
            if (n == 38) par_s = txd;
        end
        check("len_07", 32'(n), 32'd44);
        check("par_07", 32'(par_s), 32'd1);

        // Write every cycle into an idle FIFO
        baud_div    = '0;
        parity_type = 2'd0;
        acc = 0;
        rdy6 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in    = DW'(i + 1);
            data_valid = 1'b1;
            #1;
            if (tx_rdy) acc++;
            if (i == 5) rdy6 = tx_rdy;
            cycle();
        end
        check("full_accepted", 32'(acc), 32'd5);
        check("full_rdy6", 32'(rdy6), 32'd0);
        drain(200);

        // Reset during a data bit
        baud_div   = 16'd2;
        data_in    = 8'h3C;
        data_valid = 1'b1;
        cycle();
        data_in = 8'hC3;
        cycle();
        data_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        check("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        for (int i = 0; i < 40; i++) cycle();
        check("post_rst_idle", 32'(txd), 32'd1);

        // Random traffic, configuration churn, tx_en gaps, resets
        for (int c = 0; c < 4000; c++) begin
            data_valid = ($urandom_range(0, 99) < 35);
            data_in    = DW'($urandom);
            if ($urandom_range(0, 99) < 5) begin
                baud_div    = VW'($urandom_range(0, 3));
                parity_type = 2'($urandom_range(0, 3));
                nstop       = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) < 2) tx_en = ~tx_en;
            if ($urandom_range(0, 999) < 2) do_reset();
            else cycle();
        end
        tx_en = 1'b1;
        drain(500);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
